// File: rtl/sd_pkg.sv
// Shared types and constants for the SPI-mode SD single-block read engine.
package sd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_CMD,
    ST_WAIT_R1,
    ST_GET_R1,
    ST_WAIT_TOKEN,
    ST_RD_DATA,
    ST_RD_CRC,
    ST_TAIL
  } sd_state_t;

  localparam logic [7:0] CMD17            = 8'h51;
  localparam logic [7:0] DUMMY_CRC        = 8'hFF;
  localparam logic [7:0] START_TOKEN      = 8'hFE;
  localparam int         SECTOR_BYTES     = 512;
  localparam int         WORDS_PER_SECTOR = 256;
  localparam int         SECTOR_BITS      = WORDS_PER_SECTOR * 16;

  // SDSC cards take a byte address; the shift drops the top 9 sector bits.
  function automatic logic [47:0] cmd17_frame(input logic [31:0] sec_addr,
                                              input bit          byte_mode);
    logic [31:0] arg;
    arg = byte_mode ? {sec_addr[22:0], 9'd0} : sec_addr;
    return {CMD17, arg, DUMMY_CRC};
  endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI bit engine: 48-bit command shift-out, MSB-first shift-in, and a
// bit counter that emits one registered word per 16 received data bits.
module sd_spi_shifter
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [47:0] i_frame,
  input  logic        i_tx_shift,
  input  logic        i_rx_en,
  input  logic        i_miso,
  output logic        o_mosi,
  output logic [7:0]  o_r1_byte,
  output logic [12:0] o_bit_cnt,
  output logic        o_word_done,
  output logic [15:0] o_word
);

  logic [47:0] r_tx_sr;
  logic [14:0] r_rx_sr;
  logic [12:0] r_bit_cnt;
  logic        r_word_done;
  logic [15:0] r_word;

  // Ones are shifted in behind the frame so MOSI idles high once it is out.
  assign o_mosi      = r_tx_sr[47];
  assign o_r1_byte   = {r_rx_sr[6:0], i_miso};
  assign o_bit_cnt   = r_bit_cnt;
  assign o_word_done = r_word_done;
  assign o_word      = r_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_sr     <= '1;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_word_done <= 1'b0;
      r_word      <= '0;
    end else begin
      if (i_load) begin
        r_tx_sr <= i_frame;
      end else if (i_tx_shift) begin
        r_tx_sr <= {r_tx_sr[46:0], 1'b1};
      end
      r_rx_sr     <= {r_rx_sr[13:0], i_miso};
      r_word_done <= 1'b0;
      if (i_rx_en) begin
        r_bit_cnt <= r_bit_cnt + 13'd1;
        if (r_bit_cnt[3:0] == 4'hF) begin
          r_word_done <= 1'b1;
          r_word      <= {r_rx_sr, i_miso};
        end
      end else begin
        r_bit_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/sd_sector_read.sv
// CMD17 single-block read: issues the command, checks R1, waits for the
// data token, streams 256 16-bit words, skips the CRC and idles CS high.
module sd_sector_read
  import sd_pkg::*;
#(
  parameter int R1_TIMEOUT     = 64,
  parameter int TOKEN_TIMEOUT  = 100000,
  parameter int TAIL_CLKS      = 8,
  parameter bit BYTE_ADDR_MODE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        rd_start_en,
  input  logic [31:0] rd_sec_addr,
  output logic        rd_busy,
  output logic        rd_val_en,
  output logic [15:0] rd_val_data,
  output logic        rd_err,
  output logic        sd_cs,
  output logic        sd_mosi,
  input  logic        sd_miso
);

  localparam logic [16:0] CMD_LAST   = 17'd47;
  localparam logic [16:0] R1_REST    = 17'd6;
  localparam logic [16:0] CRC_LAST   = 17'd15;
  localparam logic [16:0] R1_LAST    = 17'(R1_TIMEOUT - 1);
  localparam logic [16:0] TOKEN_LAST = 17'(TOKEN_TIMEOUT - 1);
  localparam logic [16:0] TAIL_LAST  = 17'(TAIL_CLKS - 1);
  localparam logic [12:0] DATA_LAST  = 13'(SECTOR_BITS - 1);

  sd_state_t   r_state;
  logic [16:0] r_cnt;
  logic        r_busy;
  logic        r_err;
  logic        r_cs;

  logic        w_accept;
  logic        w_mosi;
  logic [7:0]  w_r1_byte;
  logic [12:0] w_bit_cnt;
  logic        w_word_done;
  logic [15:0] w_word;

  assign w_accept = (r_state == ST_IDLE) && rd_start_en && sd_init_done;

  sd_spi_shifter u_shifter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_frame     (cmd17_frame(rd_sec_addr, BYTE_ADDR_MODE)),
    .i_tx_shift  (r_state == ST_SEND_CMD),
    .i_rx_en     (r_state == ST_RD_DATA),
    .i_miso      (sd_miso),
    .o_mosi      (w_mosi),
    .o_r1_byte   (w_r1_byte),
    .o_bit_cnt   (w_bit_cnt),
    .o_word_done (w_word_done),
    .o_word      (w_word)
  );

  assign rd_busy     = r_busy;
  assign rd_err      = r_err;
  assign sd_cs       = r_cs;
  assign sd_mosi     = w_mosi;
  assign rd_val_en   = w_word_done;
  assign rd_val_data = w_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_cs    <= 1'b1;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_SEND_CMD;
            r_busy  <= 1'b1;
            r_cs    <= 1'b0;
            r_cnt   <= '0;
          end
        end
        ST_SEND_CMD: begin
          if (r_cnt == CMD_LAST) begin
            r_state <= ST_WAIT_R1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        ST_WAIT_R1: begin
          if (!sd_miso) begin
            r_state <= ST_GET_R1;
            r_cnt   <= '0;
          end else if (r_cnt == R1_LAST) begin
            r_err   <= 1'b1;
            r_cs    <= 1'b1;
            r_state <= ST_TAIL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        ST_GET_R1: begin
          if (r_cnt == R1_REST) begin
            r_cnt <= '0;
            if (w_r1_byte == 8'h00) begin
              r_state <= ST_WAIT_TOKEN;
            end else begin
              r_err   <= 1'b1;
              r_cs    <= 1'b1;
              r_state <= ST_TAIL;
            end
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        ST_WAIT_TOKEN: begin
          // The token's only zero is its last bit, so the first zero marks data start.
          if (sd_miso == START_TOKEN[0]) begin
            r_state <= ST_RD_DATA;
            r_cnt   <= '0;
          end else if (r_cnt == TOKEN_LAST) begin
            r_err   <= 1'b1;
            r_cs    <= 1'b1;
            r_state <= ST_TAIL;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        ST_RD_DATA: begin
          if (w_bit_cnt == DATA_LAST) begin
            r_state <= ST_RD_CRC;
            r_cnt   <= '0;
          end
        end
        ST_RD_CRC: begin
          if (r_cnt == CRC_LAST) begin
            r_state <= ST_TAIL;
            r_cs    <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        ST_TAIL: begin
          if (r_cnt == TAIL_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 17'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
